branch_predictor_bht: RTL

//   Parametrised branch history table: 2^INDEX_BITS saturating counters, indexed by PC (bimodal) or PC^GHR (gshare).

---
 rtl/bp_pkg.sv | 23 ++
 rtl/bp_index_hash.sv | 32 +++
 rtl/branch_predictor_bht.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared constants and counter helper for the branch history table.
package bp_pkg;

    localparam int BP_MODE_BIMODAL = 0;
    localparam int BP_MODE_GSHARE  = 1;
    localparam int STAT_W          = 32;
    localparam int CTR_MAX_W       = 32;

    // Saturating up/down step for a counter of ctr_bits width, zero-extended into CTR_MAX_W.
    function automatic logic [CTR_MAX_W-1:0] sat_update(
        input logic [CTR_MAX_W-1:0] ctr,
        input logic                 taken,
        input int unsigned          ctr_bits
    );
        logic [CTR_MAX_W-1:0] ctr_max;
        ctr_max = (CTR_MAX_W'(1) << ctr_bits) - CTR_MAX_W'(1);
        if (taken) begin
            return (ctr >= ctr_max) ? ctr : ctr + CTR_MAX_W'(1);
        end
        return (ctr == '0) ? ctr : ctr - CTR_MAX_W'(1);
    endfunction

endpackage

// File: rtl/bp_index_hash.sv
// Table index from a PC and a history value: bimodal uses PC bits only, gshare xors in the history.
module bp_index_hash
    import bp_pkg::*;
#(
    parameter int PC_BITS    = 32,
    parameter int PC_SHIFT   = 2,
    parameter int INDEX_BITS = 6,
    parameter int HIST_BITS  = 6,
    parameter int MODE       = 0
) (
    input  logic [PC_BITS-1:0]    pc_i,
    input  logic [HIST_BITS-1:0]  hist_i,
    output logic [INDEX_BITS-1:0] idx_o
);

    logic [INDEX_BITS-1:0] hist_mix;
    logic                  unused_bits;

    generate
        if (MODE == BP_MODE_GSHARE) begin : g_gshare
            assign hist_mix = INDEX_BITS'(hist_i);
        end else begin : g_bimodal
            assign hist_mix = '0;
        end
    endgenerate

    assign idx_o = pc_i[PC_SHIFT +: INDEX_BITS] ^ hist_mix;

    // Alignment bits, upper PC bits and (in bimodal) the history do not affect the index.
    assign unused_bits = ^{pc_i, hist_i};

endmodule

// File: rtl/branch_predictor_bht.sv
// Branch history table of saturating counters with 1-cycle lookup, same-cycle training,
// non-speculative global history and saturating lookup/mispredict statistics.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int PC_BITS    = 32,
    parameter int PC_SHIFT   = 2,
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int HIST_BITS  = 6,
    parameter int MODE       = 0,
    parameter int INIT_CTR   = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 lookup_valid,
    input  logic [PC_BITS-1:0]   lookup_pc,
    output logic                 pred_valid,
    output logic                 pred_taken,
    output logic [HIST_BITS-1:0] pred_ghr,
    input  logic                 update_valid,
    input  logic [PC_BITS-1:0]   update_pc,
    input  logic [HIST_BITS-1:0] update_ghr,
    input  logic                 update_taken,
    output logic [HIST_BITS-1:0] ghr,
    output logic [STAT_W-1:0]    stat_lookups,
    output logic [STAT_W-1:0]    stat_mispredicts
);

    localparam int                  ENTRIES  = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] INIT_VAL = CTR_BITS'(INIT_CTR);

    logic [CTR_BITS-1:0]   ctr_q [ENTRIES];
    logic [CTR_BITS-1:0]   ctr_d [ENTRIES];
    logic [INDEX_BITS-1:0] lkp_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [CTR_BITS-1:0]   upd_old;
    logic [CTR_BITS-1:0]   upd_new;
    logic [CTR_BITS-1:0]   lkp_ctr;
    logic                  mispredict;

    logic                  pred_valid_q, pred_valid_d;
    logic                  pred_taken_q, pred_taken_d;
    logic [HIST_BITS-1:0]  pred_ghr_q, pred_ghr_d;
    logic [HIST_BITS-1:0]  ghr_q, ghr_d, ghr_shift;
    logic [STAT_W-1:0]     lookups_q, lookups_d;
    logic [STAT_W-1:0]     mispred_q, mispred_d;

    bp_index_hash #(
        .PC_BITS    (PC_BITS),
        .PC_SHIFT   (PC_SHIFT),
        .INDEX_BITS (INDEX_BITS),
        .HIST_BITS  (HIST_BITS),
        .MODE       (MODE)
    ) u_lookup_hash (
        .pc_i   (lookup_pc),
        .hist_i (ghr_q),
        .idx_o  (lkp_idx)
    );

    bp_index_hash #(
        .PC_BITS    (PC_BITS),
        .PC_SHIFT   (PC_SHIFT),
        .INDEX_BITS (INDEX_BITS),
        .HIST_BITS  (HIST_BITS),
        .MODE       (MODE)
    ) u_update_hash (
        .pc_i   (update_pc),
        .hist_i (update_ghr),
        .idx_o  (upd_idx)
    );

    assign upd_old    = ctr_q[upd_idx];
    assign upd_new    = CTR_BITS'(sat_update(CTR_MAX_W'(upd_old), update_taken, CTR_BITS));
    assign mispredict = update_valid && (upd_old[CTR_BITS-1] != update_taken);

    always_comb begin
        ctr_d = ctr_q;
        if (update_valid) begin
            ctr_d[upd_idx] = upd_new;
        end
    end

    // Reading the post-update array forwards a same-cycle training write to the lookup.
    assign lkp_ctr = ctr_d[lkp_idx];

    generate
        if (HIST_BITS == 1) begin : g_hist_one
            assign ghr_shift = update_taken;
        end else begin : g_hist_many
            assign ghr_shift = {ghr_q[HIST_BITS-2:0], update_taken};
        end
    endgenerate

    always_comb begin
        pred_valid_d = lookup_valid;
        pred_taken_d = pred_taken_q;
        pred_ghr_d   = pred_ghr_q;
        if (lookup_valid) begin
            pred_taken_d = lkp_ctr[CTR_BITS-1];
            pred_ghr_d   = ghr_q;
        end
    end

    always_comb begin
        ghr_d     = update_valid ? ghr_shift : ghr_q;
        lookups_d = lookups_q;
        mispred_d = mispred_q;
        if (lookup_valid && (lookups_q != '1)) begin
            lookups_d = lookups_q + STAT_W'(1);
        end
        if (mispredict && (mispred_q != '1)) begin
            mispred_d = mispred_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= INIT_VAL;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_ghr_q   <= '0;
            ghr_q        <= '0;
            lookups_q    <= '0;
            mispred_q    <= '0;
        end else begin
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_ghr_q   <= pred_ghr_d;
            ghr_q        <= ghr_d;
            lookups_q    <= lookups_d;
            mispred_q    <= mispred_d;
        end
    end

    assign pred_valid       = pred_valid_q;
    assign pred_taken       = pred_taken_q;
    assign pred_ghr         = pred_ghr_q;
    assign ghr              = ghr_q;
    assign stat_lookups     = lookups_q;
    assign stat_mispredicts = mispred_q;

endmodule
